// File: rtl/period_meter_pkg.sv
// period_meter_pkg: FSM state type plus default counter width and timeout (2 s at 50 MHz) for period_meter
package period_meter_pkg;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_TIMEOUT = 100_000_000;
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, HOLD} meterState_t;
endpackage

// File: rtl/sig_sync_edge.sv
// sig_sync_edge: 2-flop synchronizer, optional 3-sample majority filter (GLITCH_FILTER_EN), rise/fall pulses; in CLK_50M nCLR sigIn, out rise fall
module sig_sync_edge (
  input  logic CLK_50M,
  input  logic nCLR,
  input  logic sigIn,
  output logic rise,
  output logic fall
);
  logic [1:0] syncQ;
  logic lvl, lvlQ;
`ifdef GLITCH_FILTER_EN
  logic [1:0] hist;
  logic maj;
  assign maj = (syncQ[1] & hist[0]) | (syncQ[1] & hist[1]) | (hist[0] & hist[1]);
  always_ff @(posedge CLK_50M or negedge nCLR)
    if (!nCLR) begin
      hist <= '0;
      lvl <= 1'b0;
    end else begin
      hist <= {hist[0], syncQ[1]};
      lvl <= maj;
    end
`else
  assign lvl = syncQ[1];
`endif
  always_ff @(posedge CLK_50M or negedge nCLR)
    if (!nCLR) begin
      syncQ <= '0;
      lvlQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], sigIn};
      lvlQ <= lvl;
    end
  assign rise = lvl & ~lvlQ;
  assign fall = ~lvl & lvlQ;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures SIG_IN period/high time in CLK_50M cycles on START, result held until VALID&READY; ports CLK_50M nCLR SIG_IN START READY -> PERIOD HIGH_TIME VALID TIMEOUT_FLG BUSY; option GLITCH_FILTER_EN
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK_50M,
  input  logic             nCLR,
  input  logic             SIG_IN,
  input  logic             START,
  input  logic             READY,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             TIMEOUT_FLG,
  output logic             BUSY
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  meterState_t state;
  logic [CNT_W-1:0] cnt, hiCnt, cntInc, hiInc;
  logic hiPhase, rise, fall, timedOut;
  sig_sync_edge u_sync (
    .CLK_50M(CLK_50M),
    .nCLR   (nCLR),
    .sigIn  (SIG_IN),
    .rise   (rise),
    .fall   (fall)
  );
  assign cntInc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign hiInc = (hiCnt == CNT_MAX) ? hiCnt : hiCnt + 1'b1;
  assign timedOut = 64'(cnt) >= 64'(TIMEOUT);
  always_ff @(posedge CLK_50M or negedge nCLR)
    if (!nCLR) begin
      state <= IDLE;
      cnt <= '0;
      hiCnt <= '0;
      hiPhase <= 1'b0;
      PERIOD <= '0;
      HIGH_TIME <= '0;
      VALID <= 1'b0;
      TIMEOUT_FLG <= 1'b0;
      BUSY <= 1'b0;
    end else
      case (state)
        IDLE:
          if (START) begin
            state <= WAIT_EDGE;
            cnt <= '0;
            hiCnt <= '0;
            hiPhase <= 1'b0;
            BUSY <= 1'b1;
          end
        WAIT_EDGE, MEASURE:
          if (rise && state == MEASURE) begin
            state <= HOLD;
            PERIOD <= cnt;
            HIGH_TIME <= hiCnt;
            TIMEOUT_FLG <= 1'b0;
            VALID <= 1'b1;
            BUSY <= 1'b0;
          end else if (rise) begin
            state <= MEASURE;
            cnt <= CNT_W'(1);
            hiCnt <= CNT_W'(1);
            hiPhase <= 1'b1;
          end else if (timedOut) begin
            state <= HOLD;
            PERIOD <= '0;
            HIGH_TIME <= '0;
            TIMEOUT_FLG <= 1'b1;
            VALID <= 1'b1;
            BUSY <= 1'b0;
          end else begin
            cnt <= cntInc;
            hiPhase <= hiPhase & ~fall;
            if (hiPhase & ~fall) hiCnt <= hiInc;
          end
        HOLD:
          if (READY) begin
            state <= IDLE;
            VALID <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized self-checking bench for period_meter against an arithmetic period/high-time model
module tb_period_meter;
  localparam int TO = 1000;
  localparam int SAT = 15;
`ifdef GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0, nCLR = 1'b0, sigIn = 1'b0, start = 1'b0, ready = 1'b0;
  logic [31:0] period, highTime;
  logic [3:0] period2, highTime2;
  logic valid, tflg, busy, valid2, tflg2, busy2;
  int nChecks = 0, nFails = 0, validCnt = 0;
  period_meter #(.CNT_W(32), .TIMEOUT(TO)) dut (
    .CLK_50M(clk), .nCLR(nCLR), .SIG_IN(sigIn), .START(start), .READY(ready),
    .PERIOD(period), .HIGH_TIME(highTime), .VALID(valid), .TIMEOUT_FLG(tflg), .BUSY(busy)
  );
  period_meter #(.CNT_W(4), .TIMEOUT(TO)) dutSat (
    .CLK_50M(clk), .nCLR(nCLR), .SIG_IN(sigIn), .START(start), .READY(ready),
    .PERIOD(period2), .HIGH_TIME(highTime2), .VALID(valid2), .TIMEOUT_FLG(tflg2), .BUSY(busy2)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > SAT ? SAT : v;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (valid) validCnt++;
    end
  endtask
  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic runPulse(input int h, input int l);
    sigIn = 1'b1;
    tick(h);
    sigIn = 1'b0;
    tick(l);
    sigIn = 1'b1;
    tick(4);
    sigIn = 1'b0;
  endtask
  task automatic waitValid(input string tag, input int bound, output int n);
    n = 0;
    while (!valid && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, valid, 1);
  endtask
  task automatic accept();
    sigIn = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("accept_valid_drop", valid, 0);
    tick(6);
  endtask
  task automatic measureCase(input string tag, input int h, input int l);
    int n;
    pulseStart();
    check({tag, "_busy"}, busy, 1);
    tick($urandom_range(3, 8));
    runPulse(h, l);
    waitValid(tag, 20, n);
    check({tag, "_period"}, period, h + l);
    check({tag, "_high"}, highTime, h);
    check({tag, "_tflg"}, tflg, 0);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_period_sat"}, period2, sat(h + l));
    check({tag, "_high_sat"}, highTime2, sat(h));
  endtask
  initial begin
    int n, h, l, k;
    bit stable;
    tick(3);
    check("rst_period", period, 0);
    check("rst_high", highTime, 0);
    check("rst_valid", valid, 0);
    check("rst_tflg", tflg, 0);
    check("rst_busy", busy, 0);
    nCLR = 1'b1;
    tick(4);
    check("idle_no_valid", valid, 0);
    ready = 1'b1;
    validCnt = 0;
    pulseStart();
    tick(4);
    runPulse(3, 7);
    tick(10);
    ready = 1'b0;
    check("p10_valid_once", validCnt, 1);
    check("p10_period", period, 10);
    check("p10_high", highTime, 3);
    tick(4);
    measureCase("sat", 20, 3);
    accept();
    pulseStart();
    tick(4);
    sigIn = 1'b1;
    tick(4);
    sigIn = 1'b0;
    tick(1);
    sigIn = 1'b1;
    tick(4);
    sigIn = 1'b0;
    tick(6);
    runPulse(4, 4);
    waitValid("glitch", 20, n);
    check("glitch_period", period, FILT ? 15 : 5);
    check("glitch_high", highTime, FILT ? 9 : 4);
    accept();
    for (int t = 0; t < 8; t++) begin
      h = $urandom_range(3, 40);
      l = $urandom_range(3, 40);
      measureCase("rnd", h, l);
      k = $urandom_range(5, 50);
      stable = 1'b1;
      for (int i = 0; i < k; i++) begin
        sigIn = 1'($urandom);
        start = 1'($urandom);
        tick();
        if (valid !== 1'b1 || period !== 32'(h + l) || highTime !== 32'(h) || busy !== 1'b0) stable = 1'b0;
      end
      start = 1'b0;
      check("rnd_hold_stable", stable, 1);
      accept();
    end
    pulseStart();
    tick(3);
    sigIn = 1'b1;
    tick(6);
    check("mid_busy", busy, 1);
    #3 nCLR = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_high", highTime, 0);
    tick(2);
    nCLR = 1'b1;
    sigIn = 1'b0;
    tick(5);
    check("post_rst_valid", valid, 0);
    check("post_rst_busy", busy, 0);
    measureCase("post_rst", 6, 9);
    accept();
    pulseStart();
    tick(10);
    check("to_wait_busy", busy, 1);
    n = 10;
    while (!valid && n < TO + 20) begin
      tick();
      n++;
    end
    check("to_wait_valid", valid, 1);
    check("to_wait_latency_ok", n >= TO && n <= TO + 2, 1);
    check("to_wait_tflg", tflg, 1);
    check("to_wait_period", period, 0);
    check("to_wait_high", highTime, 0);
    accept();
    measureCase("pre_to", 5, 5);
    accept();
    pulseStart();
    tick(4);
    sigIn = 1'b1;
    n = 0;
    while (!valid && n < TO + 20) begin
      tick();
      n++;
    end
    check("to_meas_valid", valid, 1);
    check("to_meas_tflg", tflg, 1);
    check("to_meas_period", period, 0);
    check("to_meas_high", highTime, 0);
    accept();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d failures so far", nFails);
    $fatal(1);
  end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 100000000: CLK_50M cycles allowed per measurement phase (2 s).
REQ-003 SHALL have port CLK_50M  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-004 SHALL have port nCLR  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SIG_IN  input  1  asynchronous slow signal to measure (e.g. 1 Hz divider output).
REQ-006 SHALL have port START  input  1  single-cycle request to begin a measurement.
REQ-007 SHALL have port READY  input  1  consumer accepts the result.
REQ-008 SHALL have port PERIOD  output  CNT_W  measured period in CLK_50M cycles.
REQ-009 SHALL have port HIGH_TIME  output  CNT_W  measured high time in CLK_50M cycles.
REQ-010 SHALL have port VALID  output  1  result available.
REQ-011 SHALL have port TIMEOUT_FLG  output  1  result is a timeout, qualified by VALID.
REQ-012 SHALL have port BUSY  output  1  measurement in progress.

Function
REQ-013 SIG_IN SHALL pass through a 2-flop synchronizer; rising/falling edges SHALL be detected on the synchronized value, one pulse each.
REQ-014 FSM states SHALL be IDLE, WAIT_EDGE, MEASURE, HOLD.
REQ-015 IDLE: START=1 -> WAIT_EDGE, counter cleared; START SHALL be ignored in all other states.
REQ-016 WAIT_EDGE: rising-edge pulse -> MEASURE, counter and high counter set to 1, high-phase flag set.
REQ-017 MEASURE: counter increments each cycle; high counter increments while high-phase flag set; falling-edge pulse clears the flag.
REQ-018 MEASURE: next rising-edge pulse -> HOLD; PERIOD SHALL equal cycles between the two rising pulses (10-cycle input -> 10), HIGH_TIME the cycles from rising to falling pulse.
REQ-019 PERIOD, HIGH_TIME, TIMEOUT_FLG SHALL be registered and VALID asserted in the cycle after the terminating edge pulse.
REQ-020 HOLD: outputs SHALL stay stable and VALID high until VALID&READY; that cycle -> IDLE, VALID deasserts next cycle; edges SHALL be ignored in HOLD.
REQ-021 Timeout: counter reaching TIMEOUT in WAIT_EDGE or MEASURE SHALL force HOLD with PERIOD=0, HIGH_TIME=0, TIMEOUT_FLG=1.
REQ-022 Edge pulse and timeout in the same cycle: edge SHALL win.
REQ-023 Counters SHALL saturate at all-ones, never wrap.
REQ-024 BUSY SHALL be 1 exactly in WAIT_EDGE and MEASURE.

Reset
REQ-025 nCLR low SHALL immediately force IDLE, synchronizer flops 0, counters 0, PERIOD=0, HIGH_TIME=0, VALID=0, TIMEOUT_FLG=0, BUSY=0, including mid-measurement.
REQ-026 After nCLR release, first edge detection SHALL require two synchronized samples; no spurious edge from reset values.

Configuration
REQ-027 With GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchronizer (2 extra cycles latency on both edges, pulses of 1 cycle rejected).
REQ-028 Without GLITCH_FILTER_EN, edge detection SHALL use the synchronizer output directly; 1-cycle pulses SHALL be measured.

Structure
REQ-029 Package period_meter_pkg SHALL hold the FSM state type, default CNT_W and default TIMEOUT constants.
REQ-030 Sub-module sig_sync_edge SHALL contain synchronizer, optional filter, and rise/fall pulse generation.

Verification
REQ-031 1 Hz 50 % input, START -> VALID with PERIOD=50000000, HIGH_TIME=25000000, TIMEOUT_FLG=0.
REQ-032 Period 10, high 3, READY=1 -> PERIOD=10, HIGH_TIME=3, VALID exactly 1 cycle.
REQ-033 TIMEOUT=1000, SIG_IN stuck low, START -> VALID=1, TIMEOUT_FLG=1, PERIOD=0 after 1000 cycles.
REQ-034 READY=0 for 50 cycles while edges continue -> outputs and VALID stable; START pulses ignored.
REQ-035 nCLR pulse in MEASURE -> all outputs 0, IDLE; new START measures correctly.
REQ-036 1-cycle glitch in high phase -> counted without GLITCH_FILTER_EN, ignored with it.
